// File: rtl/kf_pkg.sv
// Shared types and constants for the Kalman sample sequencer.
package kf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_START = 3'd1,
        P_WAIT  = 3'd2,
        U_START = 3'd3,
        U_WAIT  = 3'd4,
        OUT     = 3'd5
    } kf_seq_state_t;

    localparam int unsigned KF_CNT_W = 16;  // completed-sample counter width
    localparam int unsigned KF_WIDTH = 16;  // default fixed-point word width
    localparam int unsigned KF_WD_W  = 10;  // watchdog counter width

endpackage

// File: rtl/kf_watchdog.sv
// Wait-state watchdog: counts enabled cycles spent in a WAIT state and flags expiry
// once TIMEOUT enabled cycles have elapsed there. Only built with KF_WATCHDOG_EN.
module kf_watchdog
    import kf_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam logic [KF_WD_W-1:0] Limit = KF_WD_W'(TIMEOUT - 1);

    logic [KF_WD_W-1:0] cnt_q, cnt_d;

    // Clear on the cycle before a WAIT is entered; saturate at the limit while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The TIMEOUT-th enabled edge in a WAIT state is the one that sees the limit.
    assign expired = active && (cnt_q == Limit);

    // Counter register, gated by the clock enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clk_en) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kf_sample_sequencer.sv
// Sample-level controller ahead of the Kalman state-equation stage. Captures one (U, Y)
// sample, starts prediction then update, captures X_nkP / X_nkU and offers them downstream.
// Optional feature: define KF_WATCHDOG_EN to abort stuck WAIT states after TIMEOUT enabled
// cycles and raise a sticky err flag.
module kf_sample_sequencer
    import kf_pkg::*;
#(
    parameter int unsigned WIDTH   = KF_WIDTH,
    parameter int unsigned nos     = 4,
    parameter int unsigned noo     = 2,
    parameter int unsigned noi     = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [noi-1:0][WIDTH-1:0]     U_in,
    input  logic [noo-1:0][WIDTH-1:0]     Y_in,
    output logic [noi-1:0][WIDTH-1:0]     U,
    output logic [noo-1:0][WIDTH-1:0]     Y,
    output logic                          Start_Prediction,
    output logic                          Start_Update,
    input  logic                          ready_Prediction,
    input  logic                          ready_Update,
    input  logic [nos-1:0][WIDTH-1:0]     X_nkP,
    input  logic [nos-1:0][WIDTH-1:0]     X_nkU,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [nos-1:0][WIDTH-1:0]     X_pred,
    output logic [nos-1:0][WIDTH-1:0]     X_est,
    output logic [KF_CNT_W-1:0]           sample_cnt,
    output logic                          err
);

    kf_seq_state_t                state_q, state_d;
    logic [noi-1:0][WIDTH-1:0]    u_q, u_d;
    logic [noo-1:0][WIDTH-1:0]    y_q, y_d;
    logic [nos-1:0][WIDTH-1:0]    x_pred_q, x_pred_d;
    logic [nos-1:0][WIDTH-1:0]    x_est_q, x_est_d;
    logic [KF_CNT_W-1:0]          sample_cnt_q, sample_cnt_d;
    logic                         wd_expired;

`ifdef KF_WATCHDOG_EN
    logic wd_clear;
    logic wd_active;
    logic err_q, err_d;

    // Every START state is followed by its WAIT, so clearing in START arms a fresh count.
    assign wd_clear  = (state_q == P_START) || (state_q == U_START);
    assign wd_active = (state_q == P_WAIT)  || (state_q == U_WAIT);

    kf_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_kf_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .clear   (wd_clear),
        .active  (wd_active),
        .expired (wd_expired)
    );

    // Sticky error: set on any expiry, cleared only by reset.
    always_comb begin
        err_d = err_q | wd_expired;
    end

    assign err = err_q;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    // Next-state and data-capture logic; registers hold unless a transition loads them.
    always_comb begin
        state_d      = state_q;
        u_d          = u_q;
        y_d          = y_q;
        x_pred_d     = x_pred_q;
        x_est_d      = x_est_q;
        sample_cnt_d = sample_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    u_d     = U_in;
                    y_d     = Y_in;
                    state_d = P_START;
                end
            end
            P_START: state_d = P_WAIT;
            P_WAIT: begin
                if (ready_Prediction) begin
                    x_pred_d = X_nkP;
                    state_d  = U_START;
                end else if (wd_expired) begin
                    state_d = IDLE;
                end
            end
            U_START: state_d = U_WAIT;
            U_WAIT: begin
                // A ready arriving on the expiry cycle still completes the sample.
                if (ready_Update) begin
                    x_est_d      = X_nkU;
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    state_d      = OUT;
                end else if (wd_expired) begin
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state; they hold while clk_en is low.
    assign in_ready         = (state_q == IDLE);
    assign Start_Prediction = (state_q == P_START);
    assign Start_Update     = (state_q == U_START);
    assign out_valid        = (state_q == OUT);
    assign U                = u_q;
    assign Y                = y_q;
    assign X_pred           = x_pred_q;
    assign X_est            = x_est_q;
    assign sample_cnt       = sample_cnt_q;

    // State and data registers with asynchronous active-low reset, gated by clk_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            u_q          <= '0;
            y_q          <= '0;
            x_pred_q     <= '0;
            x_est_q      <= '0;
            sample_cnt_q <= '0;
`ifdef KF_WATCHDOG_EN
            err_q        <= 1'b0;
`endif
        end else if (clk_en) begin
            state_q      <= state_d;
            u_q          <= u_d;
            y_q          <= y_d;
            x_pred_q     <= x_pred_d;
            x_est_q      <= x_est_d;
            sample_cnt_q <= sample_cnt_d;
`ifdef KF_WATCHDOG_EN
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_kf_sample_sequencer.sv
// Bench for kf_sample_sequencer: directed and randomized samples against a simple
// transaction-level expectation (captured values, pulse lengths, sample count).
module tb_kf_sample_sequencer;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NOS     = 4;
    localparam int unsigned NOO     = 2;
    localparam int unsigned NOI     = 2;
    localparam int unsigned TIMEOUT = 20;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        clk_en;
    logic                        in_valid;
    logic                        in_ready;
    logic [NOI-1:0][WIDTH-1:0]   U_in;
    logic [NOO-1:0][WIDTH-1:0]   Y_in;
    logic [NOI-1:0][WIDTH-1:0]   U;
    logic [NOO-1:0][WIDTH-1:0]   Y;
    logic                        Start_Prediction;
    logic                        Start_Update;
    logic                        ready_Prediction;
    logic                        ready_Update;
    logic [NOS-1:0][WIDTH-1:0]   X_nkP;
    logic [NOS-1:0][WIDTH-1:0]   X_nkU;
    logic                        out_valid;
    logic                        out_ready;
    logic [NOS-1:0][WIDTH-1:0]   X_pred;
    logic [NOS-1:0][WIDTH-1:0]   X_est;
    logic [15:0]                 sample_cnt;
    logic                        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          en_period = 1;
    logic [15:0] exp_cnt  = 16'd0;

    kf_sample_sequencer #(
        .WIDTH   (WIDTH),
        .nos     (NOS),
        .noo     (NOO),
        .noi     (NOI),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_en           (clk_en),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .U_in             (U_in),
        .Y_in             (Y_in),
        .U                (U),
        .Y                (Y),
        .Start_Prediction (Start_Prediction),
        .Start_Update     (Start_Update),
        .ready_Prediction (ready_Prediction),
        .ready_Update     (ready_Update),
        .X_nkP            (X_nkP),
        .X_nkU            (X_nkU),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .X_pred           (X_pred),
        .X_est            (X_est),
        .sample_cnt       (sample_cnt),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs and clk_en for the following edge are set 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        clk_en = (en_period <= 1) ? 1'b1 : ((cyc % en_period) == 0);
    endtask

    // Advance until exactly one enabled edge has passed.
    task automatic en_step();
        logic was_en;
        do begin
            was_en = clk_en;
            step();
        end while (!was_en);
    endtask

    task automatic set_en(input int p);
        en_period = p;
        cyc       = 0;
        clk_en    = 1'b1;
    endtask

    task automatic capture(input logic [31:0] u, input logic [31:0] y);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        ready_Prediction = 1'b0;
        ready_Update     = 1'b0;
        in_valid = 1'b1;
        U_in     = u;
        Y_in     = y;
        en_step();
        in_valid = 1'b0;
        check("u_capture", {32'd0, U}, {32'd0, u});
        check("y_capture", {32'd0, Y}, {32'd0, y});
    endtask

    // The pulse must last exactly one enabled cycle, i.e. en_period clocks.
    task automatic count_pulse(input bit upd, input string tag);
        int n   = 0;
        int bad = 0;
        while ((upd ? Start_Update : Start_Prediction) && n < 64) begin
            if (upd ? Start_Prediction : Start_Update) bad++;
            step();
            n++;
        end
        check(tag, 64'(n), 64'(en_period));
        check({tag, "_other_quiet"}, 64'(bad), 64'd0);
    endtask

    task automatic run_sample(input logic [31:0] u, input logic [31:0] y,
                              input logic [63:0] xp, input logic [63:0] xu,
                              input int latp, input int latu, input int hold);
        capture(u, y);
        count_pulse(1'b0, "start_pred_len");
        repeat (latp) en_step();
        check("p_wait_quiet", {61'd0, Start_Prediction, Start_Update, out_valid}, 64'd0);
        ready_Prediction = 1'b1;
        X_nkP            = xp;
        en_step();
        X_nkP = ~xp;
        count_pulse(1'b1, "start_upd_len");
        check("x_pred_cap", X_pred, xp);
        repeat (latu) en_step();
        check("u_wait_quiet", {62'd0, Start_Update, out_valid}, 64'd0);
        ready_Update = 1'b1;
        X_nkU        = xu;
        out_ready    = (hold == 0);
        en_step();
        X_nkU   = ~xu;
        exp_cnt = exp_cnt + 16'd1;
        check("out_valid_set", {63'd0, out_valid}, 64'd1);
        check("x_pred_out", X_pred, xp);
        check("x_est_out", X_est, xu);
        check("sample_cnt", {48'd0, sample_cnt}, {48'd0, exp_cnt});
        check("in_ready_busy", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            U_in     = ~u;
            Y_in     = ~y;
            step();
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_x_est", X_est, xu);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        en_step();
        out_ready = 1'b0;
        check("out_done", {62'd0, out_valid, in_ready}, 64'd1);
        check("u_held", {32'd0, U}, {32'd0, u});
        check("y_held", {32'd0, Y}, {32'd0, y});
    endtask

    initial begin
        logic [31:0] nu;
        logic [31:0] ny;
        logic [63:0] nxp;
        logic [63:0] nxu;

        nu  = {16'h0200, 16'h0100};
        ny  = {16'h0020, 16'h0010};
        nxp = 64'h0004_0003_0002_0001;
        nxu = 64'h0040_0030_0020_0010;

        reset            = 1'b0;
        clk_en           = 1'b1;
        in_valid         = 1'b0;
        U_in             = '0;
        Y_in             = '0;
        ready_Prediction = 1'b0;
        ready_Update     = 1'b0;
        X_nkP            = '0;
        X_nkU            = '0;
        out_ready        = 1'b0;

        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_ctrl", {60'd0, Start_Prediction, Start_Update, out_valid, err}, 64'd0);
        check("rst_data", {X_pred ^ X_est}, 64'd0);
        check("rst_cnt", {48'd0, sample_cnt}, 64'd0);
        reset = 1'b1;
        step();

        // Nominal sample with 8 cycles of output backpressure.
        set_en(1);
        run_sample(nu, ny, nxp, nxu, 5, 5, 8);

        // Randomized samples, enable patterns and latencies.
        for (int k = 0; k < 6; k++) begin
            set_en(int'($urandom_range(1, 3)));
            run_sample($urandom, $urandom, {$urandom, $urandom}, {$urandom, $urandom},
                       int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 3)));
        end

        // Enable every 3rd clock: same results as nominal, pulses 3 clocks long.
        set_en(3);
        run_sample(nu, ny, nxp, nxu, 5, 5, 0);

        // Counter wrap: force the count to its maximum while idle.
        set_en(1);
        force dut.sample_cnt_q = 16'hFFFF;
        step();
        release dut.sample_cnt_q;
        exp_cnt = 16'hFFFF;
        run_sample(nu, ny, nxp, nxu, 1, 1, 0);
        check("wrap_zero", {48'd0, sample_cnt}, 64'd0);

`ifdef KF_WATCHDOG_EN
        begin
            int n       = 0;
            int saw_out = 0;
            set_en(2);
            capture(nu, ny);
            count_pulse(1'b0, "wd_pred_len");
            ready_Prediction = 1'b1;
            X_nkP            = nxp;
            en_step();
            count_pulse(1'b1, "wd_upd_len");
            while (!in_ready && n < 200) begin
                if (out_valid) saw_out++;
                en_step();
                n++;
            end
            check("wd_cycles", 64'(n), 64'(TIMEOUT));
            check("wd_err", {63'd0, err}, 64'd1);
            check("wd_no_out", 64'(saw_out) | {63'd0, out_valid}, 64'd0);
            check("wd_cnt_kept", {48'd0, sample_cnt}, {48'd0, exp_cnt});
            step();
            check("wd_err_sticky", {63'd0, err}, 64'd1);
        end
`else
        check("err_tied_low", {63'd0, err}, 64'd0);
`endif

        // Reset in the middle of P_WAIT.
        set_en(1);
        capture(nu, ny);
        count_pulse(1'b0, "mid_pred_len");
        step();
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_ctrl", {60'd0, Start_Prediction, Start_Update, out_valid, err}, 64'd0);
        check("mid_rst_cnt", {48'd0, sample_cnt}, 64'd0);
        check("mid_rst_u", {32'd0, U}, 64'd0);
        #2;
        reset            = 1'b1;
        ready_Prediction = 1'b0;
        ready_Update     = 1'b0;
        exp_cnt          = 16'd0;
        step();

        run_sample(nu, ny, nxp, nxu, 2, 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
